// File: rtl/minmax_stream_if.sv
// Stream-in / result-out bundle for minmax_stream.
// master = upstream producer and result consumer; slave = the min/max block.
interface minmax_stream_if #(
  parameter int unsigned W        = 12,
  parameter int unsigned NL       = 4,
  parameter int unsigned MAXBEATS = 256,
  parameter int unsigned IDXW     = (NL * MAXBEATS > 1) ? $clog2(NL * MAXBEATS) : 1,
  parameter int unsigned BCW      = $clog2(MAXBEATS + 1)
);
  logic            us_sel;
  logic            in_valid;
  logic            in_ready;
  logic [NL*W-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    min_val;
  logic [IDXW-1:0] min_idx;
  logic [W-1:0]    max_val;
  logic [IDXW-1:0] max_idx;
  logic [BCW-1:0]  beat_cnt;
  logic            ovf;

  modport master (
    output us_sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, min_val, min_idx, max_val, max_idx, beat_cnt, ovf
  );

  modport slave (
    input  us_sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, min_val, min_idx, max_val, max_idx, beat_cnt, ovf
  );
endinterface

// File: rtl/minmax_stream.sv
// Streaming frame min/max tracker: NL lanes per beat, running min/max with global
// element indices, per-frame signed/unsigned mode, one registered result per frame.
module minmax_stream #(
  parameter int unsigned W        = 12,
  parameter int unsigned NL       = 4,
  parameter int unsigned MAXBEATS = 256,
  parameter int unsigned CFG      = 0
) (
  input  logic               clk,
  input  logic               rst,
  minmax_stream_if.slave     bus
);
  localparam int unsigned IDXW = (NL * MAXBEATS > 1) ? $clog2(NL * MAXBEATS) : 1;
  localparam int unsigned BCW  = $clog2(MAXBEATS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_signed;
  logic [BCW-1:0]  r_beats;
  logic [W-1:0]    r_run_min;
  logic [IDXW-1:0] r_run_min_idx;
  logic [W-1:0]    r_run_max;
  logic [IDXW-1:0] r_run_max_idx;
  logic [W-1:0]    r_min_val;
  logic [IDXW-1:0] r_min_idx;
  logic [W-1:0]    r_max_val;
  logic [IDXW-1:0] r_max_idx;
  logic [BCW-1:0]  r_beat_cnt;
  logic            r_ovf;

  logic            w_first;
  logic            w_mode;
  logic            w_accept;
  logic            w_close;
  logic [BCW-1:0]  w_beat_num;
  logic [BCW-1:0]  w_beats_inc;
  logic [IDXW-1:0] w_base;
  logic [W-1:0]    w_lane;
  logic [W-1:0]    w_bmin;
  logic [IDXW-1:0] w_bmin_idx;
  logic [W-1:0]    w_bmax;
  logic [IDXW-1:0] w_bmax_idx;
  logic            w_upd_min;
  logic            w_upd_max;
  logic [W-1:0]    w_fmin;
  logic [IDXW-1:0] w_fmin_idx;
  logic [W-1:0]    w_fmax;
  logic [IDXW-1:0] w_fmax_idx;

  function automatic logic f_lt(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    if (sgn) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // The first beat of a frame takes its mode from us_sel and starts at beat 0.
  assign w_first     = (r_state == ST_IDLE);
  assign w_mode      = w_first ? bus.us_sel : r_signed;
  assign w_beat_num  = w_first ? '0 : r_beats;
  assign w_beats_inc = w_beat_num + BCW'(1);
  assign w_base      = IDXW'(w_beat_num) * IDXW'(NL);
  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_close     = bus.in_last || (w_beats_inc == BCW'(MAXBEATS));

  // Lane reduction of the current beat; strict compares keep the lowest lane on ties.
  always_comb begin
    w_lane     = '0;
    w_bmin     = bus.in_data[W-1:0];
    w_bmax     = bus.in_data[W-1:0];
    w_bmin_idx = w_base;
    w_bmax_idx = w_base;
    for (int unsigned k = 1; k < NL; k++) begin
      w_lane = bus.in_data[k*W +: W];
      if (f_lt(w_lane, w_bmin, w_mode)) begin
        w_bmin     = w_lane;
        w_bmin_idx = w_base + IDXW'(k);
      end
      if (f_lt(w_bmax, w_lane, w_mode)) begin
        w_bmax     = w_lane;
        w_bmax_idx = w_base + IDXW'(k);
      end
    end
  end

  // Merge with running values; earlier beats win ties, so the smallest index survives.
  assign w_upd_min  = w_first || f_lt(w_bmin, r_run_min, w_mode);
  assign w_upd_max  = w_first || f_lt(r_run_max, w_bmax, w_mode);
  assign w_fmin     = w_upd_min ? w_bmin     : r_run_min;
  assign w_fmin_idx = w_upd_min ? w_bmin_idx : r_run_min_idx;
  assign w_fmax     = w_upd_max ? w_bmax     : r_run_max;
  assign w_fmax_idx = w_upd_max ? w_bmax_idx : r_run_max_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ACC: if (w_accept) w_state_nxt = w_close ? ST_DONE : ST_ACC;
      ST_DONE:         if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != ST_DONE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_signed      <= 1'b0;
      r_beats       <= '0;
      r_run_min     <= '0;
      r_run_min_idx <= '0;
      r_run_max     <= '0;
      r_run_max_idx <= '0;
      r_min_val     <= '0;
      r_min_idx     <= '0;
      r_max_val     <= '0;
      r_max_idx     <= '0;
      r_beat_cnt    <= '0;
      r_ovf         <= 1'b0;
    end else if (w_accept) begin
      r_signed      <= w_mode;
      r_beats       <= w_beats_inc;
      r_run_min     <= w_fmin;
      r_run_min_idx <= w_fmin_idx;
      r_run_max     <= w_fmax;
      r_run_max_idx <= w_fmax_idx;
      if (w_close) begin
        r_min_val  <= w_fmin;
        r_min_idx  <= (CFG != 0) ? '0 : w_fmin_idx;
        r_max_val  <= w_fmax;
        r_max_idx  <= (CFG != 0) ? '0 : w_fmax_idx;
        r_beat_cnt <= w_beats_inc;
        r_ovf      <= ~bus.in_last;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.min_val   = r_min_val;
  assign bus.min_idx   = r_min_idx;
  assign bus.max_val   = r_max_val;
  assign bus.max_idx   = r_max_idx;
  assign bus.beat_cnt  = r_beat_cnt;
  assign bus.ovf       = r_ovf;
endmodule
